// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the PC unit and the instruction decoder.
//   pc_op_e      : next-PC operation encoding (INC, BRANCH, JUMP, JAL)
//   COND_*       : 4-bit condition-code constants used by BRANCH and JUMP
//   FLAG_*       : bit positions inside the 5-bit flag word {C,L,F,Z,N}
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JAL    = 2'd3
  } pc_op_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if -- control/status bundle between the control FSM and pc_unit.
//   master : control side, drives pc_enable, pc_op, cond, disp, target,
//            flag_we, flags_in; reads pc_out, flags_out, taken, link_out
//   slave  : pc_unit side, the reverse directions
interface pc_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic              pc_enable;
  pc_op_e            pc_op;
  logic [3:0]        cond;
  logic [7:0]        disp;
  logic [ADDR_W-1:0] target;
  logic              flag_we;
  logic [4:0]        flags_in;
  logic [ADDR_W-1:0] pc_out;
  logic [4:0]        flags_out;
  logic              taken;
  logic [ADDR_W-1:0] link_out;

  modport master (
    output pc_enable, pc_op, cond, disp, target, flag_we, flags_in,
    input  pc_out, flags_out, taken, link_out
  );

  modport slave (
    input  pc_enable, pc_op, cond, disp, target, flag_we, flags_in,
    output pc_out, flags_out, taken, link_out
  );
endinterface

// File: rtl/cond_eval.sv
// cond_eval -- combinational condition-code evaluation against a flag word.
//   cond  : 4-bit condition code (COND_* in cpu_pkg)
//   flags : flag word {C,L,F,Z,N}
//   true  : high when the condition holds
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       true
);

  // Decode the condition code into a single truth bit.
  always_comb begin
    true = 1'b0;
    case (cond)
      COND_EQ: true = flags[FLAG_Z];
      COND_NE: true = ~flags[FLAG_Z];
      COND_CS: true = flags[FLAG_C];
      COND_CC: true = ~flags[FLAG_C];
      COND_HI: true = flags[FLAG_L];
      COND_LS: true = ~flags[FLAG_L];
      COND_GT: true = flags[FLAG_N];
      COND_LE: true = ~flags[FLAG_N];
      COND_FS: true = flags[FLAG_F];
      COND_FC: true = ~flags[FLAG_F];
      COND_LO: true = ~flags[FLAG_L] & ~flags[FLAG_Z];
      COND_HS: true = flags[FLAG_L] | flags[FLAG_Z];
      COND_LT: true = ~flags[FLAG_N] & ~flags[FLAG_Z];
      COND_GE: true = flags[FLAG_N] | flags[FLAG_Z];
      COND_UC: true = 1'b1;
      COND_NV: true = 1'b0;
      default: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- program counter, flag register and optional link register.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous, active-low reset
//   bus    : pc_unit_if.slave (pc_enable, pc_op, cond, disp, target,
//            flag_we, flags_in in; pc_out, flags_out, taken, link_out out)
// Build option: define PC_UNIT_LINK_EN to enable JAL with a link register;
// otherwise JAL behaves as INC and link_out is tied to zero.
// ADDR_W must exceed 8 (the displacement is sign-extended from 8 bits).
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [4:0]        flags_q, flags_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] disp_ext_s;
  logic              cond_true_s;
`ifdef PC_UNIT_LINK_EN
  logic [ADDR_W-1:0] link_q, link_d;
`endif

  // Conditions always see the registered (pre-edge) flags.
  cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (flags_q),
    .true  (cond_true_s)
  );

  assign pc_inc_s   = pc_q + PC_ONE;
  assign disp_ext_s = {{(ADDR_W-8){bus.disp[7]}}, bus.disp};

  // Next-state selection for PC, taken, link and flags.
  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef PC_UNIT_LINK_EN
    link_d  = link_q;
`endif
    if (bus.pc_enable) begin
      case (bus.pc_op)
        PC_INC: begin
          pc_d = pc_inc_s;
        end
        PC_BRANCH: begin
          if (cond_true_s) begin
            pc_d    = pc_q + disp_ext_s;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        PC_JUMP: begin
          if (cond_true_s) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        PC_JAL: begin
`ifdef PC_UNIT_LINK_EN
          pc_d    = bus.target;
          link_d  = pc_inc_s;
          taken_d = 1'b1;
`else
          pc_d = pc_inc_s;
`endif
        end
        default: begin
          pc_d = pc_inc_s;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end

    if (bus.flag_we) begin
      flags_d = bus.flags_in;
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      flags_q <= 5'd0;
      taken_q <= 1'b0;
`ifdef PC_UNIT_LINK_EN
      link_q  <= {ADDR_W{1'b0}};
`endif
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
`ifdef PC_UNIT_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.flags_out = flags_q;
  assign bus.taken     = taken_q;
`ifdef PC_UNIT_LINK_EN
  assign bus.link_out  = link_q;
`else
  assign bus.link_out  = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed and randomized checks of pc_unit against a
// behavioural model that tracks PC/flags/link as plain integers.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int AW  = 16;
  localparam int MOD = 65536;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(AW)) bus ();

  pc_unit #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int       m_pc;
  int       m_link;
  bit [4:0] m_flags;
  bit       m_taken;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Condition truth from named flags {C,L,F,Z,N}.
  function automatic bit holds(input int c, input bit [4:0] f);
    bit fc, fl, ff, fz, fn;
    fc = f[4]; fl = f[3]; ff = f[2]; fz = f[1]; fn = f[0];
    if (c == 0)  return fz;
    if (c == 1)  return !fz;
    if (c == 2)  return fc;
    if (c == 3)  return !fc;
    if (c == 4)  return fl;
    if (c == 5)  return !fl;
    if (c == 6)  return fn;
    if (c == 7)  return !fn;
    if (c == 8)  return ff;
    if (c == 9)  return !ff;
    if (c == 10) return !fl && !fz;
    if (c == 11) return fl || fz;
    if (c == 12) return !fn && !fz;
    if (c == 13) return fn || fz;
    if (c == 14) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_link = 0; m_flags = 5'd0; m_taken = 1'b0;
  endtask

  // Model of one rising edge, using the inputs currently on the bus.
  task automatic model_edge();
    int  op, d, nxt;
    bit  ok;
    op  = int'(bus.pc_op);
    ok  = holds(int'(bus.cond), m_flags);
    d   = (int'(bus.disp) >= 128) ? int'(bus.disp) - 256 : int'(bus.disp);
    nxt = (m_pc + 1) % MOD;
    m_taken = 1'b0;
    if (bus.pc_enable) begin
      if (op == 1 && ok) begin
        nxt = (m_pc + d + MOD) % MOD; m_taken = 1'b1;
      end else if (op == 2 && ok) begin
        nxt = int'(bus.target); m_taken = 1'b1;
      end else if (op == 3) begin
`ifdef PC_UNIT_LINK_EN
        m_link = (m_pc + 1) % MOD;
        nxt = int'(bus.target); m_taken = 1'b1;
`endif
      end
      m_pc = nxt;
    end
    if (bus.flag_we) m_flags = bus.flags_in;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},    32'(bus.pc_out),    32'(m_pc));
    check({tag, ".taken"}, 32'(bus.taken),     32'(m_taken));
    check({tag, ".flags"}, 32'(bus.flags_out), 32'(m_flags));
    check({tag, ".link"},  32'(bus.link_out),  32'(m_link));
  endtask

  // Drive one cycle's inputs, clock it, update model, compare.
  task automatic step(input string tag, input bit en, input int op, input int c,
                      input int dsp, input int tgt, input bit fwe, input int fin);
    bus.pc_enable = en;
    bus.pc_op     = pc_op_e'(op[1:0]);
    bus.cond      = c[3:0];
    bus.disp      = dsp[7:0];
    bus.target    = tgt[15:0];
    bus.flag_we   = fwe;
    bus.flags_in  = fin[4:0];
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic go_to(input int pc);
    step("goto", 1'b1, 2, 14, 0, pc, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.pc_enable = 1'b0; bus.pc_op = PC_INC; bus.cond = 4'd0; bus.disp = 8'd0;
    bus.target = 16'd0; bus.flag_we = 1'b0; bus.flags_in = 5'd0;
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Three INC pulses: 1, 2, 3 with taken low.
    step("inc1", 1'b1, 0, 0, 0, 0, 1'b0, 0);
    step("inc2", 1'b1, 0, 0, 0, 0, 1'b0, 0);
    step("inc3", 1'b1, 0, 0, 0, 0, 1'b0, 0);
    check("inc3_const", 32'(bus.pc_out), 32'h3);

    // BRANCH EQ backwards with Z set, then with Z clear.
    go_to(16'h0010);
    step("setz", 1'b0, 0, 0, 0, 0, 1'b1, 5'b00010);
    step("beq_t", 1'b1, 1, 0, 8'hFC, 0, 1'b0, 0);
    check("beq_t_const", 32'(bus.pc_out), 32'h000C);
    check("beq_t_taken", 32'(bus.taken), 32'h1);
    step("idle", 1'b0, 0, 0, 0, 0, 1'b0, 0);
    check("taken_drop", 32'(bus.taken), 32'h0);
    go_to(16'h0010);
    step("clrz", 1'b0, 0, 0, 0, 0, 1'b1, 5'b00000);
    step("beq_nt", 1'b1, 1, 0, 8'hFC, 0, 1'b0, 0);
    check("beq_nt_const", 32'(bus.pc_out), 32'h0011);

    // Wrap-around.
    go_to(16'hFFFF);
    step("wrap_inc", 1'b1, 0, 0, 0, 0, 1'b0, 0);
    check("wrap_inc_const", 32'(bus.pc_out), 32'h0000);
    go_to(16'h0002);
    step("wrap_br", 1'b1, 1, 14, 8'h80, 0, 1'b0, 0);
    check("wrap_br_const", 32'(bus.pc_out), 32'hFF82);

    // Same-edge flag write: branch uses old flags.
    step("clrz2", 1'b0, 0, 0, 0, 0, 1'b1, 5'b00000);
    step("beq_old", 1'b1, 1, 0, 8'h04, 0, 1'b1, 5'b00010);
    check("beq_old_taken", 32'(bus.taken), 32'h0);
    step("beq_new", 1'b1, 1, 0, 8'h04, 0, 1'b0, 0);
    check("beq_new_taken", 32'(bus.taken), 32'h1);

    // JAL.
    go_to(16'h0040);
    step("jal", 1'b1, 3, 15, 0, 16'h0100, 1'b0, 0);
`ifdef PC_UNIT_LINK_EN
    check("jal_pc_const", 32'(bus.pc_out), 32'h0100);
    check("jal_link_const", 32'(bus.link_out), 32'h0041);
`else
    check("jal_pc_const", 32'(bus.pc_out), 32'h0041);
    check("jal_link_const", 32'(bus.link_out), 32'h0000);
`endif

    // Reset between edges with a JUMP pending.
    go_to(16'h0333);
    bus.pc_enable = 1'b1; bus.pc_op = PC_JUMP; bus.cond = COND_UC; bus.target = 16'h1234;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_now_pc", 32'(bus.pc_out), 32'h0);
    check_state("rst_now");
    @(posedge clk);
    #1;
    check_state("rst_edge");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 1'b1, 0, 0, 0, 0, 1'b0, 0);
    check("post_rst_const", 32'(bus.pc_out), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, program-counter value loaded on reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_enable  input  1  advance strobe from the control FSM, high during the execute/write-back state.
REQ-006 SHALL have port pc_op  input  2  next-PC operation: 0 INC, 1 BRANCH, 2 JUMP, 3 JAL.
REQ-007 SHALL have port cond  input  4  condition code for BRANCH and JUMP.
REQ-008 SHALL have port disp  input  8  signed branch displacement, two's complement.
REQ-009 SHALL have port target  input  ADDR_W  absolute jump target, from a register operand.
REQ-010 SHALL have port flag_we  input  1  flag-register write enable.
REQ-011 SHALL have port flags_in  input  5  ALU flags {C,L,F,Z,N}.
REQ-012 SHALL have port pc_out  output  ADDR_W  current PC, the instruction-memory address.
REQ-013 SHALL have port flags_out  output  5  flag-register contents.
REQ-014 SHALL have port taken  output  1  registered; high for one cycle after a redirecting update.
REQ-015 SHALL have port link_out  output  ADDR_W  link register, the return address.

Function
REQ-016 Condition evaluation SHALL be combinational from flags_out:
- EQ=0 Z; NE=1 !Z; CS=2 C; CC=3 !C; HI=4 L; LS=5 !L
- GT=6 N; LE=7 !N; FS=8 F; FC=9 !F; LO=10 !L&!Z; HS=11 L|Z
- LT=12 !N&!Z; GE=13 N|Z; UC=14 always; 15 never
REQ-017 With pc_enable=0, pc_out, link_out and taken SHALL hold, with taken forced to 0 on that edge.
REQ-018 With pc_enable=1, INC SHALL load pc_out+1.
REQ-019 With pc_enable=1, BRANCH SHALL load pc_out+sign_extend(disp) if the condition is true, else pc_out+1.
REQ-020 With pc_enable=1, JUMP SHALL load target if the condition is true, else pc_out+1.
REQ-021 All PC arithmetic SHALL be modulo 2^ADDR_W; wrap-around SHALL be silent, with no error signal.
REQ-022 taken SHALL be registered as 1 exactly when the loaded PC came from a true BRANCH, JUMP or JAL.
REQ-023 Flags SHALL load flags_in on any edge with flag_we=1, independent of pc_enable.
REQ-024 When flag_we and a conditional pc_op coincide, the condition SHALL use the pre-edge flags (old value).
REQ-025 Latency: a new pc_out SHALL be visible one clock after the pc_enable edge, with no combinational input-to-pc_out path.

Reset
REQ-026 Reset SHALL force pc_out=RESET_PC, flags_out=0, taken=0 and link_out=0 immediately, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending update.
REQ-028 The first edge after reset release with pc_enable=1 SHALL act on RESET_PC.

Configuration
REQ-029 Macro PC_UNIT_LINK_EN SHALL control JAL support.
REQ-030 With PC_UNIT_LINK_EN defined, JAL SHALL unconditionally load pc_out<=target and link_out<=old pc_out+1, ignoring cond.
REQ-031 With PC_UNIT_LINK_EN undefined, JAL SHALL behave exactly as INC, and link_out SHALL be constant 0 with no link register.

Structure
REQ-032 Shared package cpu_pkg SHALL hold:
- the pc_op encodings
- the 4-bit condition-code constants
- the flag bit indices C=4, L=3, F=2, Z=1, N=0
REQ-033 Condition evaluation SHALL be the sub-module cond_eval (inputs cond and flags; output true), reusable by the decoder.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset low then released, three pc_enable pulses with INC -> pc_out 0,1,2,3; taken stays 0.
- pc_out=0x0010, flags Z=1, BRANCH EQ, disp=0xFC -> pc_out=0x000C, taken=1 for one cycle; same with Z=0 -> 0x0011, taken=0.
- pc_out=0xFFFF, INC -> 0x0000; pc_out=0x0002, BRANCH UC, disp=0x80 -> 0xFF82.
- flags Z=0, same edge flag_we=1 with flags_in Z=1 and BRANCH EQ -> not taken; next edge with BRANCH EQ -> taken.
- pc_out=0x0040, JAL target=0x0100 (macro on) -> pc_out=0x0100, link_out=0x0041; macro off -> pc_out=0x0041, link_out=0.
- Reset asserted between edges while pc_enable=1 with JUMP pending -> pc_out=RESET_PC immediately and after the next edge.
